// File: rtl/debug_unit_if.sv
// Bundle of UART, instruction-memory and pipeline-debug signals between the
// debug unit (master side) and the surrounding system (slave side).
interface debug_unit_if #(
  parameter int IMEM_DEPTH = 256
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_en;
  logic          cpu_rst;
  logic          cpu_halted;
  logic [4:0]    dbg_reg_sel;
  logic [31:0]   dbg_reg_data;
  logic [31:0]   dbg_pc;

  modport master (
    input  rx_data, rx_valid, tx_busy, cpu_halted, dbg_reg_data, dbg_pc,
    output tx_data, tx_start, imem_we, imem_addr, imem_wdata,
           cpu_en, cpu_rst, dbg_reg_sel
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, cpu_halted, dbg_reg_data, dbg_pc,
    input  tx_data, tx_start, imem_we, imem_addr, imem_wdata,
           cpu_en, cpu_rst, dbg_reg_sel
  );
endinterface

// File: rtl/debug_unit.sv
// Host command engine for the MIPS pipeline: loads program words from UART,
// runs or single-steps the core, then streams PC, cycle count and registers.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command byte ('L', 'C', 'S')
// LOAD      | core held in reset, assembling LE bytes into imem words
// LOAD_ACK  | sending 'K' once the transmitter is free, then release core
// RUN       | core enabled until cpu_halted is seen
// STEP      | single enabled cycle has just been issued
// DUMP      | waiting for tx_busy low to send the next dump byte
// DUMP_WAIT | one-cycle gap after each tx_start before re-checking busy
module debug_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic         clk_in,
  input logic         Reset,
  debug_unit_if.master bus
);

  localparam int            AW        = $clog2(IMEM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
  localparam logic [7:0]    CMD_LOAD  = 8'h4C;
  localparam logic [7:0]    CMD_CONT  = 8'h43;
  localparam logic [7:0]    CMD_STEP  = 8'h53;
  localparam logic [7:0]    ACK_BYTE  = 8'h4B;
  localparam logic [7:0]    DUMP_LEN  = 8'd136;

  typedef enum logic [2:0] {
    IDLE, LOAD, LOAD_ACK, RUN, STEP, DUMP, DUMP_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    dump_idx_q, dump_idx_d;
  logic [31:0]   cycle_cnt_q, cycle_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          cpu_en_q, cpu_en_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic [4:0]    reg_sel_q, reg_sel_d;

  logic [31:0]   dump_field;
  logic [7:0]    dump_byte;
  logic [7:0]    dump_next;
  logic          load_done;

  always_ff @(posedge clk_in or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      dump_idx_q   <= '0;
      cycle_cnt_q  <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_en_q     <= 1'b0;
      cpu_rst_q    <= 1'b0;
      reg_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      dump_idx_q   <= dump_idx_d;
      cycle_cnt_q  <= cycle_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_en_q     <= cpu_en_d;
      cpu_rst_q    <= cpu_rst_d;
      reg_sel_q    <= reg_sel_d;
    end
  end

  // reg_sel_q is advanced together with the byte index, so dbg_reg_data
  // already reflects the right register when the byte is latched.
  always_comb begin
    dump_field = bus.dbg_reg_data;
    if (dump_idx_q < 8'd4)
      dump_field = bus.dbg_pc;
    else if (dump_idx_q < 8'd8)
      dump_field = cycle_cnt_q;
    dump_byte = 8'(dump_field >> {dump_idx_q[1:0], 3'b000});
    dump_next = dump_idx_q + 8'd1;
    load_done = imem_we_q && ((imem_wdata_q == HALT_WORD) || (imem_addr_q == LAST_ADDR));
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    dump_idx_d   = dump_idx_q;
    cycle_cnt_d  = cycle_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_en_d     = cpu_en_q;
    cpu_rst_d    = cpu_rst_q;
    reg_sel_d    = reg_sel_q;

    if (cpu_en_q)
      cycle_cnt_d = cycle_cnt_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_LOAD: begin
              state_d     = LOAD;
              cpu_rst_d   = 1'b1;
              imem_addr_d = '0;
              byte_idx_d  = '0;
              cycle_cnt_d = '0;
            end
            CMD_CONT: begin
              state_d  = RUN;
              cpu_en_d = !bus.cpu_halted;
            end
            CMD_STEP: begin
              if (bus.cpu_halted) begin
                state_d = DUMP;
              end else begin
                state_d  = STEP;
                cpu_en_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (load_done)
          state_d = LOAD_ACK;
        else if (imem_we_q)
          imem_addr_d = imem_addr_q + AW'(1);
        if (!load_done && bus.rx_valid) begin
          imem_wdata_d = {bus.rx_data, imem_wdata_q[31:8]};
          byte_idx_d   = byte_idx_q + 2'd1;
          imem_we_d    = (byte_idx_q == 2'd3);
        end
      end
      LOAD_ACK: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          cpu_rst_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      RUN: begin
        if (bus.cpu_halted) begin
          cpu_en_d = 1'b0;
          state_d  = DUMP;
        end else begin
          cpu_en_d = 1'b1;
        end
      end
      STEP: begin
        cpu_en_d = 1'b0;
        state_d  = DUMP;
      end
      DUMP: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = dump_byte;
          dump_idx_d = dump_next;
          reg_sel_d  = (dump_next >= 8'd8) ? 5'((dump_next - 8'd8) >> 2) : 5'd0;
          state_d    = DUMP_WAIT;
        end
      end
      DUMP_WAIT: begin
        if (dump_idx_q == DUMP_LEN) begin
          dump_idx_d = '0;
          reg_sel_d  = '0;
          state_d    = IDLE;
        end else begin
          state_d = DUMP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wdata  = imem_wdata_q;
  assign bus.cpu_en      = cpu_en_q;
  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.dbg_reg_sel = reg_sel_q;

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side control block sitting directly upstream of the MIPS pipeline. It receives command bytes from the UART receiver, loads program words into instruction memory, and runs the pipeline either continuously or one clock at a time. After each run or step it streams PC, cycle count and all 32 registers back through the UART transmitter. It replaces the bench-driven reset/run sequence with a self-contained load → run/step → dump loop.

## Interface
- IMEM_DEPTH, 256: instruction memory depth in words; imem_addr width = clog2(IMEM_DEPTH).
- HALT_WORD, 32'hFFFF_FFFF: terminator word that ends a load; it is also written to memory.
- clk_in  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  out  8  byte to transmit; held stable while tx_start is high.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy; rises no later than 1 cycle after tx_start.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  clog2(IMEM_DEPTH)  word address.
- imem_wdata  out  32  word to write.
- cpu_en  out  1  pipeline clock enable; the pipeline advances only while it is high.
- cpu_rst  out  1  active-high synchronous soft reset to the pipeline.
- cpu_halted  in  1  high once HALT_WORD has retired in WB; sticky until cpu_rst.
- dbg_reg_sel  out  5  register file debug read select.
- dbg_reg_data  in  32  combinational register read for dbg_reg_sel.
- dbg_pc  in  32  current PC.

## Operation
- FSM states: IDLE, LOAD, LOAD_ACK, RUN, STEP, DUMP, DUMP_WAIT.
- Reset values: tx_data=0, tx_start=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_en=0, cpu_rst=0, dbg_reg_sel=0. Byte index = 0, cycle counter = 0, state = IDLE.
- In IDLE, the block acts on each rx_valid byte:
  - 0x4C 'L' → LOAD.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP.
  - Any other byte is ignored.
- rx_valid bytes are ignored in every state except IDLE and LOAD.
- LOAD:
  - On entry: cpu_rst=1 (held for the whole state), imem_addr=0, cycle counter cleared.
  - Bytes are assembled little-endian into 32-bit words.
  - After the 4th byte of a word: imem_we pulses with the assembled word, then imem_addr increments.
  - Exit to LOAD_ACK after writing a word equal to HALT_WORD, or after writing address IMEM_DEPTH-1. imem_addr does not wrap.
- LOAD_ACK: send a single byte 0x4B 'K', drop cpu_rst, return to IDLE.
- RUN:
  - cpu_en=1 until cpu_halted is sampled high, then → DUMP.
  - If cpu_halted is already high on entry, cpu_en is never asserted.
- STEP:
  - cpu_en=1 for exactly one cycle, then → DUMP.
  - If cpu_halted is high, no enable cycle occurs; go straight to DUMP.
- Cycle counter: 32-bit, increments on every cycle with cpu_en=1, wraps 0xFFFF_FFFF→0.
- DUMP streams 136 bytes, each 32-bit field sent LSB first:
  - Bytes 0–3: dbg_pc.
  - Bytes 4–7: cycle counter.
  - Bytes 8–135: registers r0..r31; dbg_reg_sel = (index-8)>>2.
  - Each byte is latched into tx_data at the moment tx_start is issued.
  - After byte 135 → IDLE.
- cpu_en stays 0 throughout DUMP, so the captured values are frozen.

## Timing
- imem_we is high exactly in the cycle after the rx_valid of the word's 4th byte. imem_addr/imem_wdata are valid in that same cycle.
- RUN: cpu_en rises 1 cycle after 'C' is received.
  - If cpu_halted is high in cycle N, cpu_en is low from N+1 on.
  - The counter includes cycle N.
- STEP: cpu_en is high in the single cycle after 'S' is received; DUMP starts the cycle after that.
- TX handshake:
  - tx_start is issued only when tx_busy=0 and the block is in DUMP (or LOAD_ACK).
  - After each tx_start the FSM spends one cycle in DUMP_WAIT before re-checking tx_busy.
  - This guarantees one tx_start per byte, at most every 2 cycles.
- Reset asserted mid-operation: immediate return to the reset values.
  - A partial word in LOAD is discarded.
  - A partial dump is abandoned and is not resumed.

## Test plan
- Load: 'L' + bytes 0x01,0x00,0x00,0x20 + FF×4 → two imem_we pulses: addr0=0x2000_0001, addr1=0xFFFF_FFFF. cpu_rst is high throughout; then tx byte 0x4B.
- Step: after load, 'S' → exactly one cpu_en cycle, then 136 tx bytes. Bytes 4–7 = 01 00 00 00; bytes 8–11 = r0 = 0.
- Run: program of 5 instructions + HALT_WORD, then 'C' → cpu_en runs until cpu_halted. The dump shows the counter equal to the number of enabled cycles and the register values written by the program.
- Halted: 'S' or 'C' sent while cpu_halted=1 → no cpu_en pulse, dump is sent, counter unchanged.
- Back-pressure: hold tx_busy high for 20 cycles mid-dump → no tx_start while busy, no byte lost or duplicated, total of 136 tx_start pulses.
- Reset: drive Reset low after the 2nd byte of a load word → outputs return to reset values. A following 'S' with no reload produces a dump whose counter bytes start 01 00 00 00.
